// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing a single fp_addsub_24 unit among N_REQ requesters.
// One operation in flight; the result/status is routed back to the granted requester.
module fp_addsub_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 24,
  parameter int STAT_W  = 8,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_op,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [STAT_W-1:0]      rsp_status,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [WIDTH-1:0]       fu_a,
  output logic [WIDTH-1:0]       fu_b,
  output logic                   fu_op,
  output logic                   fu_enable,
  input  logic [WIDTH-1:0]       fu_result,
  input  logic [STAT_W-1:0]      fu_status,
  input  logic                   fu_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, cur_id, win, cand;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  // First pending request at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fu_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack         <= '0;
      rsp_valid   <= '0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_status  <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      fu_a        <= '0;
      fu_b        <= '0;
      fu_op       <= 1'b0;
      fu_enable   <= 1'b0;
      ptr         <= '0;
      cur_id      <= '0;
      cnt         <= '0;
    end else begin
      ack       <= '0;
      rsp_valid <= '0;
      busy      <= (state_nxt != IDLE);
      unique case (state)
        IDLE: if (found) begin
          ack    <= N_REQ'(1) << win;
          fu_a   <= req_a[win*WIDTH +: WIDTH];
          fu_b   <= req_b[win*WIDTH +: WIDTH];
          fu_op  <= req_op[win];
          cur_id <= win;
          ptr    <= (int'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
        end
        ISSUE: begin
          fu_enable <= 1'b1;
          cnt       <= '0;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Response fields are loaded on the WAIT exit edge so they are
          // already valid during the RESP cycle.
          if (fu_done) begin
            rsp_result  <= fu_result;
            rsp_status  <= fu_status;
            rsp_timeout <= 1'b0;
            rsp_id      <= cur_id;
            rsp_valid   <= N_REQ'(1) << cur_id;
            fu_enable   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result  <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_valid   <= N_REQ'(1) << cur_id;
            fu_enable   <= 1'b0;
          end
        end
        RESP:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Randomized bench for fp_addsub_arbiter: queue-based round-robin reference model
// plus a behavioural unit model with configurable latency and stale done.
module tb_fp_addsub_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req, req_op;
  logic [95:0] req_a, req_b;
  logic [3:0]  ack, rsp_valid;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_result;
  logic [7:0]  rsp_status;
  logic        rsp_timeout, busy;
  logic [23:0] fu_a, fu_b;
  logic        fu_op, fu_enable;
  logic [23:0] fu_result;
  logic [7:0]  fu_status;
  logic        fu_done;

  fp_addsub_arbiter #(.N_REQ(4), .WIDTH(24), .STAT_W(8), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .busy(busy), .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op), .fu_enable(fu_enable),
    .fu_result(fu_result), .fu_status(fu_status), .fu_done(fu_done)
  );

  always #5 clock = ~clock;

  int total = 0, passed = 0, cyc = 0;
  int mptr = 0;
  int lat_lo = 1, lat_hi = 4, cur_lat = -1, en_cnt = 0;
  bit stale = 1'b0;

  logic [23:0] opa [4];
  logic [23:0] opb [4];
  logic        opop[4];

  int          ack_q[$], ack_cyc_q[$], en_cyc_q[$], done_cyc_q[$], rsp_cyc_q[$];
  logic [23:0] iss_a_q[$], iss_b_q[$], rsp_res_q[$];
  logic        iss_op_q[$], rsp_to_q[$];
  logic [7:0]  unit_stat_q[$], rsp_stat_q[$];
  logic [3:0]  rsp_vld_q[$];
  logic [1:0]  rsp_id_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [23:0] unit_fn(input logic [23:0] a, input logic [23:0] b, input logic op);
    return op ? a - b : a + b;
  endfunction

  function automatic int rr_pick(input logic [3:0] pend, input int p);
    for (int k = 0; k < 4; k++)
      if (pend[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic clear_queues();
    ack_q.delete(); ack_cyc_q.delete(); en_cyc_q.delete(); done_cyc_q.delete();
    rsp_cyc_q.delete(); iss_a_q.delete(); iss_b_q.delete(); iss_op_q.delete();
    unit_stat_q.delete(); rsp_stat_q.delete(); rsp_res_q.delete(); rsp_to_q.delete();
    rsp_vld_q.delete(); rsp_id_q.delete();
  endtask

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*24 +: 24] = opa[i];
      req_b[i*24 +: 24] = opb[i];
      req_op[i]         = opop[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      opa[i]  = 24'($urandom);
      opb[i]  = 24'($urandom);
      opop[i] = 1'($urandom);
    end
    drive_ops();
  endtask

  // One clock: monitor outputs, emulate requesters dropping req on ack, run the unit model.
  task automatic cycle();
    @(negedge clock);
    cyc++;
    if (ack != 4'b0) begin
      chk("ack_onehot", 64'($countones(ack)), 64'd1);
      for (int i = 0; i < 4; i++) if (ack[i]) ack_q.push_back(i);
      ack_cyc_q.push_back(cyc);
      req = req & ~ack;
    end
    if (rsp_valid != 4'b0) begin
      rsp_cyc_q.push_back(cyc);
      rsp_vld_q.push_back(rsp_valid);
      rsp_id_q.push_back(rsp_id);
      rsp_res_q.push_back(rsp_result);
      rsp_stat_q.push_back(rsp_status);
      rsp_to_q.push_back(rsp_timeout);
    end
    if (fu_enable) begin
      if (en_cnt == 0) begin
        en_cyc_q.push_back(cyc);
        iss_a_q.push_back(fu_a);
        iss_b_q.push_back(fu_b);
        iss_op_q.push_back(fu_op);
        cur_lat = (lat_hi < 0) ? -1 : int'($urandom_range(unsigned'(lat_hi), unsigned'(lat_lo)));
      end
      en_cnt++;
      if (cur_lat > 0 && en_cnt == cur_lat) begin
        fu_done   = 1'b1;
        fu_result = unit_fn(fu_a, fu_b, fu_op);
        fu_status = 8'($urandom);
        unit_stat_q.push_back(fu_status);
        done_cyc_q.push_back(cyc);
      end else fu_done = stale;
    end else begin
      en_cnt  = 0;
      fu_done = stale;
    end
  endtask

  // Raise 'mask' now; 'raise2' is raised again during WAIT of the first op.
  task automatic run_batch(input string nm, input logic [3:0] mask, input logic [3:0] raise2, input bit exp_to);
    int exp_w[$];
    logic [3:0] pend;
    int w, start, budget;
    bit raised;
    clear_queues();
    pend = mask;
    while (pend != 4'b0) begin
      w = rr_pick(pend, mptr);
      exp_w.push_back(w);
      mptr = (w + 1) % 4;
      pend[w] = 1'b0;
      if (exp_w.size() == 1) pend = pend | raise2;
    end
    start  = cyc;
    req    = req | mask;
    raised = 1'b0;
    budget = 400;
    while (rsp_cyc_q.size() < exp_w.size() && budget > 0) begin
      cycle();
      budget--;
      if (ack_cyc_q.size() == 1 && cyc == ack_cyc_q[0]) chk({nm, "_busy_on"}, 64'(busy), 64'd1);
      if (!raised && raise2 != 4'b0 && ack_cyc_q.size() == 1 && cyc == ack_cyc_q[0] + 1) begin
        req = req | raise2;
        raised = 1'b1;
      end
    end
    chk({nm, "_rsp_count"}, 64'(rsp_cyc_q.size()), 64'(exp_w.size()));
    if (rsp_cyc_q.size() == exp_w.size() && ack_q.size() == exp_w.size() && en_cyc_q.size() == exp_w.size()) begin
      chk({nm, "_ack_latency"}, 64'(ack_cyc_q[0]), 64'(start + 1));
      for (int k = 0; k < exp_w.size(); k++) begin
        w = exp_w[k];
        chk({nm, "_grant"},     64'(ack_q[k]),     64'(w));
        chk({nm, "_en_delay"},  64'(en_cyc_q[k]),  64'(ack_cyc_q[k] + 1));
        chk({nm, "_fu_a"},      64'(iss_a_q[k]),   64'(opa[w]));
        chk({nm, "_fu_b"},      64'(iss_b_q[k]),   64'(opb[w]));
        chk({nm, "_fu_op"},     64'(iss_op_q[k]),  64'(opop[w]));
        chk({nm, "_rsp_id"},    64'(rsp_id_q[k]),  64'(w));
        chk({nm, "_rsp_valid"}, 64'(rsp_vld_q[k]), 64'(4'b1 << w));
        chk({nm, "_timeout"},   64'(rsp_to_q[k]),  64'(exp_to));
        if (exp_to) begin
          chk({nm, "_to_result"}, 64'(rsp_res_q[k]),  64'd0);
          chk({nm, "_to_status"}, 64'(rsp_stat_q[k]), 64'd0);
          chk({nm, "_to_delay"},  64'(rsp_cyc_q[k]),  64'(ack_cyc_q[k] + 65));
        end else if (k < done_cyc_q.size()) begin
          chk({nm, "_result"},    64'(rsp_res_q[k]),  64'(unit_fn(opa[w], opb[w], opop[w])));
          chk({nm, "_status"},    64'(rsp_stat_q[k]), 64'(unit_stat_q[k]));
          chk({nm, "_rsp_delay"}, 64'(rsp_cyc_q[k]),  64'(done_cyc_q[k] + 1));
        end
      end
    end
    cycle();
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_no_extra"},  64'(rsp_cyc_q.size()), 64'(exp_w.size()));
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    req = '0; req_a = '0; req_b = '0; req_op = '0;
    fu_result = '0; fu_status = '0; fu_done = 1'b0;
    repeat (2) cycle();
    chk("rst_ack",       64'(ack),       64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_fu_enable", 64'(fu_enable), 64'd0);
    chk("rst_result",    64'(rsp_result),64'd0);
    chk("rst_fu_a",      64'(fu_a),      64'd0);
    reset = 1'b0;
    cycle();

    // Single op with the fixed operands
    opa[0] = 24'h2EF0A3; opb[0] = 24'h2EF0A3; opop[0] = 1'b0;
    drive_ops();
    lat_lo = 3; lat_hi = 3;
    run_batch("single", 4'b0001, 4'b0000, 1'b0);

    // All four at once, then wrap from requester 3 back to 0
    lat_lo = 1; lat_hi = 5;
    rand_ops();
    run_batch("all4", 4'b1111, 4'b0000, 1'b0);
    rand_ops();
    run_batch("wrap", 4'b1000, 4'b1001, 1'b0);

    // Unit never completes: timeout abort, then a normal op
    lat_hi = -1;
    rand_ops();
    run_batch("timeout", 4'b0100, 4'b0000, 1'b1);
    lat_lo = 1; lat_hi = 4;
    rand_ops();
    run_batch("after_to", 4'b0010, 4'b0000, 1'b0);

    // Reset during WAIT
    clear_queues();
    lat_hi = -1;
    rand_ops();
    req = 4'b0010;
    budget = 50;
    while (ack_cyc_q.size() == 0 && budget > 0) begin cycle(); budget--; end
    chk("rstw_ack_seen", 64'(ack_cyc_q.size()), 64'd1);
    repeat (3) cycle();
    chk("rstw_in_wait", 64'(fu_enable), 64'd1);
    req = 4'b0000;
    reset = 1'b1;
    #1;
    chk("rstw_fu_enable", 64'(fu_enable), 64'd0);
    chk("rstw_busy",      64'(busy),      64'd0);
    repeat (2) cycle();
    reset = 1'b0;
    mptr = 0;
    repeat (3) cycle();
    chk("rstw_no_rsp", 64'(rsp_cyc_q.size()), 64'd0);
    lat_lo = 1; lat_hi = 4;
    rand_ops();
    run_batch("post_rst_ptr", 4'b0101, 4'b0000, 1'b0);
    rand_ops();
    run_batch("post_rst_r2", 4'b0100, 4'b0000, 1'b0);

    // Stale done high through IDLE and ISSUE
    clear_queues();
    lat_hi = -1;
    stale = 1'b1;
    fu_result = 24'h5A5A5A;
    fu_status = 8'hC3;
    rand_ops();
    repeat (3) cycle();
    chk("stale_idle_rsp",  64'(rsp_cyc_q.size()), 64'd0);
    chk("stale_idle_busy", 64'(busy), 64'd0);
    req = 4'b0010;
    budget = 50;
    while (rsp_cyc_q.size() == 0 && budget > 0) begin cycle(); budget--; end
    chk("stale_rsp_count", 64'(rsp_cyc_q.size()), 64'd1);
    if (rsp_cyc_q.size() == 1 && ack_cyc_q.size() == 1) begin
      chk("stale_rsp_delay", 64'(rsp_cyc_q[0]),  64'(ack_cyc_q[0] + 2));
      chk("stale_result",    64'(rsp_res_q[0]),  64'h5A5A5A);
      chk("stale_status",    64'(rsp_stat_q[0]), 64'hC3);
      chk("stale_id",        64'(rsp_id_q[0]),   64'd1);
      chk("stale_timeout",   64'(rsp_to_q[0]),   64'd0);
    end
    mptr = 2;
    stale = 1'b0;
    cycle();

    // Randomized batches
    lat_lo = 1; lat_hi = 6;
    for (int n = 0; n < 15; n++) begin
      rand_ops();
      run_batch("rand", 4'($urandom_range(15, 1)), 4'b0000, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
